// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester, response and ALU-drive signals of alu_arbiter
interface alu_arbiter_if #(
   parameter int DW = 8,
   parameter int CW = 4
);
   logic [1:0]    req_valid;
   logic [1:0]    req_ready;
   logic [DW-1:0] req_opa [2];
   logic [DW-1:0] req_opb [2];
   logic [CW-1:0] req_cmd [2];
   logic [1:0]    req_mode;
   logic [1:0]    req_cin;
   logic [1:0]    rsp_valid;
   logic [1:0]    rsp_ready;
   logic [DW:0]   rsp_res;
   logic [5:0]    rsp_flags;
   logic          alu_ce;
   logic [1:0]    alu_inp_valid;
   logic [DW-1:0] alu_opa;
   logic [DW-1:0] alu_opb;
   logic [CW-1:0] alu_cmd;
   logic          alu_mode;
   logic          alu_cin;
   logic [DW:0]   alu_res;
   logic          alu_cout, alu_oflow, alu_g, alu_e, alu_l, alu_err;
   modport slave (
      input  req_valid, req_opa, req_opb, req_cmd, req_mode, req_cin, rsp_ready,
      input  alu_res, alu_cout, alu_oflow, alu_g, alu_e, alu_l, alu_err,
      output req_ready, rsp_valid, rsp_res, rsp_flags,
      output alu_ce, alu_inp_valid, alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin
   );
   modport master (
      output req_valid, req_opa, req_opb, req_cmd, req_mode, req_cin, rsp_ready,
      output alu_res, alu_cout, alu_oflow, alu_g, alu_e, alu_l, alu_err,
      input  req_ready, rsp_valid, rsp_res, rsp_flags,
      input  alu_ce, alu_inp_valid, alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin
   );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one multi-cycle ALU, one op in flight; define ALU_ARB_FIXED_PRIO_EN for requester-0 priority
module alu_arbiter #(
   parameter int DW      = 8,
   parameter int CW      = 4,
   parameter int LAT     = 1,
   parameter int MUL_LAT = 3
) (
   input  logic         i_clk,
   input  logic         i_rst,
   output logic         o_busy,
   alu_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   state_t        r_state, w_next;
   logic          r_gnt, w_gnt, w_any, w_mul;
   logic [DW-1:0] r_opa, r_opb;
   logic [CW-1:0] r_cmd;
   logic          r_mode, r_cin;
   logic [7:0]    r_cnt;
   logic [DW:0]   r_res, w_res;
   logic [5:0]    r_flags, w_flags;

   assign w_any = |bus.req_valid;
   assign w_mul = r_mode && (r_cmd == CW'(4'h9) || r_cmd == CW'(4'hA));

`ifdef ALU_ARB_FIXED_PRIO_EN
   assign w_gnt = ~bus.req_valid[0];
`else
   logic r_ptr;
   assign w_gnt = (&bus.req_valid) ? r_ptr : bus.req_valid[1];
   // after each completed response, favour the requester that was not served
   always_ff @(posedge i_clk)
      if (i_rst) r_ptr <= 1'b0;
      else if (r_state == RESP && bus.rsp_ready[r_gnt]) r_ptr <= ~r_gnt;
`endif

   // state register
   always_ff @(posedge i_clk)
      r_state <= i_rst ? IDLE : w_next;

   // next state: grant, one issue cycle, count down latency, hold until consumed
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = w_any ? ISSUE : IDLE;
         ISSUE:   w_next = WAIT;
         WAIT:    w_next = (r_cnt == 8'd1) ? RESP : WAIT;
         RESP:    w_next = bus.rsp_ready[r_gnt] ? IDLE : RESP;
         default: w_next = IDLE;
      endcase
   end

   // only a definite 1 from the ALU is taken as 1; x and z fold to 0
   always_comb begin
      for (int i = 0; i <= DW; i++) w_res[i] = (bus.alu_res[i] === 1'b1);
      w_flags = {bus.alu_cout === 1'b1, bus.alu_oflow === 1'b1, bus.alu_g === 1'b1,
                 bus.alu_e === 1'b1, bus.alu_l === 1'b1, bus.alu_err === 1'b1};
   end

   // operand latch on grant, latency counter, result capture on the last WAIT cycle
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_gnt   <= 1'b0;
         r_opa   <= '0;
         r_opb   <= '0;
         r_cmd   <= '0;
         r_mode  <= 1'b0;
         r_cin   <= 1'b0;
         r_cnt   <= '0;
         r_res   <= '0;
         r_flags <= '0;
      end else begin
         if (r_state == IDLE && w_any) begin
            r_gnt  <= w_gnt;
            r_opa  <= bus.req_opa[w_gnt];
            r_opb  <= bus.req_opb[w_gnt];
            r_cmd  <= bus.req_cmd[w_gnt];
            r_mode <= bus.req_mode[w_gnt];
            r_cin  <= bus.req_cin[w_gnt];
         end
         if (r_state == ISSUE) r_cnt <= w_mul ? 8'(MUL_LAT) : 8'(LAT);
         if (r_state == WAIT) r_cnt <= r_cnt - 8'd1;
         if (r_state == WAIT && r_cnt == 8'd1) begin
            r_res   <= w_res;
            r_flags <= w_flags;
         end
      end
   end

   // handshake and ALU drive decoded from state; ALU enable also held during reset
   always_comb begin
      bus.req_ready     = (!i_rst && r_state == IDLE && w_any) ? (w_gnt ? 2'b10 : 2'b01) : 2'b00;
      bus.rsp_valid     = (!i_rst && r_state == RESP) ? (r_gnt ? 2'b10 : 2'b01) : 2'b00;
      bus.rsp_res       = r_res;
      bus.rsp_flags     = r_flags;
      bus.alu_ce        = i_rst || r_state == ISSUE || r_state == WAIT;
      bus.alu_inp_valid = (!i_rst && r_state == ISSUE) ? 2'b11 : 2'b00;
      bus.alu_opa       = r_opa;
      bus.alu_opb       = r_opb;
      bus.alu_cmd       = r_cmd;
      bus.alu_mode      = r_mode;
      bus.alu_cin       = r_cin;
      o_busy            = !i_rst && r_state != IDLE;
   end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: vector table, hand sequences and random traffic against a transaction-level model
module tb_alu_arbiter;
   localparam int LAT     = 1;
   localparam int MUL_LAT = 3;
`ifdef ALU_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic busy;
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   due = -100;
   logic [14:0] m_out = '0;
   int   ptr = 0;
   int   pend [2];
   logic [7:0] ra [2];
   logic [7:0] rb [2];
   logic [3:0] rc [2];
   logic       rm [2];
   logic       rci [2];

   always #5 clk = ~clk;

   alu_arbiter_if #(.DW(8), .CW(4)) bus ();

   alu_arbiter #(.DW(8), .CW(4), .LAT(LAT), .MUL_LAT(MUL_LAT)) dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .o_busy (busy),
      .bus    (bus)
   );

   // reference ALU: {res[8:0], cout, oflow, g, e, l, err}
   function automatic logic [14:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] c, input logic m, input logic ci);
      logic [8:0] s;
      s = 9'(a) + 9'(b) + 9'(ci);
      if (m && c == 4'h0) return {s, s[8], s[8], 4'b0000};
      if (m && c == 4'h8) return {9'h000, 2'b00, a > b, a == b, a < b, 1'b0};
      if (m && (c == 4'h9 || c == 4'hA)) return {9'((9'(a) + 9'd1) * (9'(b) + 9'd1)), 6'b000000};
      return {1'b0, a & b, 5'b00000, c > 4'hA};
   endfunction

   function automatic int lat_of(input logic [3:0] c, input logic m);
      return (m && (c == 4'h9 || c == 4'hA)) ? MUL_LAT : LAT;
   endfunction

   // ALU model: result shows only in the one cycle it is due, poison otherwise
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.alu_ce && bus.alu_inp_valid == 2'b11) begin
         due   <= cyc + lat_of(bus.alu_cmd, bus.alu_mode);
         m_out <= alu_fn(bus.alu_opa, bus.alu_opb, bus.alu_cmd, bus.alu_mode, bus.alu_cin);
      end
   end

   always_comb
      {bus.alu_res, bus.alu_cout, bus.alu_oflow, bus.alu_g, bus.alu_e, bus.alu_l, bus.alu_err} =
         (cyc == due) ? m_out : {9'h1AA, 6'h3F};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive_req(input int n, input logic [7:0] a, input logic [7:0] b, input logic [3:0] c, input logic m, input logic ci);
      bus.req_valid[n] = 1'b1;
      bus.req_opa[n]   = a;
      bus.req_opb[n]   = b;
      bus.req_cmd[n]   = c;
      bus.req_mode[n]  = m;
      bus.req_cin[n]   = ci;
   endtask

   task automatic rand_op(input int n);
      logic [3:0] cmds [6];
      cmds = '{4'h0, 4'h8, 4'h9, 4'hA, 4'hB, 4'h3};
      ra[n]  = 8'($urandom);
      rb[n]  = 8'($urandom);
      rc[n]  = cmds[$urandom_range(5)];
      rm[n]  = 1'($urandom_range(1));
      rci[n] = 1'($urandom_range(1));
      drive_req(n, ra[n], rb[n], rc[n], rm[n], rci[n]);
      pend[n] = 1;
   endtask

   // one transaction from the IDLE state: grant, issue, response, optional backpressure, consume
   task automatic serve(input int hold, output int gnt, output int lat, output logic [8:0] res, output logic [5:0] flg);
      int  g0;
      bit  got;
      gnt = 0;
      lat = -1;
      res = '0;
      flg = '0;
      got = 0;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (bus.req_ready != 2'b00) begin
            got = 1;
            break;
         end
         @(negedge clk);
      end
      chk("grant_seen", 32'(got), 1);
      if (!got) return;
      gnt = bus.req_ready[1] ? 1 : 0;
      chk("ready_onehot", $countones(bus.req_ready), 1);
      g0 = cyc;
      @(negedge clk);
      bus.req_valid[gnt] = 1'b0;
      chk("issue_inp_valid", 32'(bus.alu_inp_valid), 2'b11);
      chk("issue_ce", 32'(bus.alu_ce), 1);
      got = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.rsp_valid != 2'b00) begin
            got = 1;
            break;
         end
      end
      chk("rsp_seen", 32'(got), 1);
      if (!got) return;
      lat = cyc - g0;
      chk("rsp_valid_sel", 32'(bus.rsp_valid), gnt ? 2'b10 : 2'b01);
      res = bus.rsp_res;
      flg = bus.rsp_flags;
      bus.rsp_ready = (gnt == 1) ? 2'b01 : 2'b10;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_valid", 32'(bus.rsp_valid), gnt ? 2'b10 : 2'b01);
         chk("hold_stable", {bus.rsp_flags, bus.rsp_res}, {flg, res});
         chk("hold_busy", 32'(busy), 1);
         chk("hold_req_ready", 32'(bus.req_ready), 0);
      end
      bus.rsp_ready = (gnt == 1) ? 2'b10 : 2'b01;
      @(negedge clk);
      bus.rsp_ready = 2'b00;
      chk("done_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("done_busy", 32'(busy), 0);
   endtask

   typedef struct {
      int         rq;
      logic [7:0] a, b;
      logic [3:0] c;
      logic       m, ci;
      logic [8:0] res;
      logic [5:0] flg;
      int         lat;
   } vec_t;

   initial begin
      vec_t       vt [8];
      int         g, l, eg, seen;
      int         ce [4];
      logic [8:0] r;
      logic [5:0] f;
      logic [14:0] ex;
      vt[0] = '{0, 8'h05, 8'h03, 4'h0, 1'b1, 1'b0, 9'h008, 6'b000000, 3};
      vt[1] = '{0, 8'h02, 8'h03, 4'h9, 1'b1, 1'b0, 9'h00C, 6'b000000, 5};
      vt[2] = '{1, 8'h11, 8'h11, 4'h8, 1'b1, 1'b0, 9'h000, 6'b000100, 3};
      vt[3] = '{1, 8'hFF, 8'h01, 4'h0, 1'b1, 1'b0, 9'h100, 6'b110000, 3};
      vt[4] = '{0, 8'h03, 8'h04, 4'hA, 1'b1, 1'b0, 9'h014, 6'b000000, 5};
      vt[5] = '{1, 8'hF0, 8'h3C, 4'h9, 1'b0, 1'b0, 9'h030, 6'b000000, 3};
      vt[6] = '{0, 8'h20, 8'h10, 4'h8, 1'b1, 1'b1, 9'h000, 6'b001000, 3};
      vt[7] = '{1, 8'h0F, 8'hFF, 4'hB, 1'b1, 1'b0, 9'h00F, 6'b000001, 3};
      ce = FIXED ? '{0, 0, 0, 0} : '{0, 1, 0, 1};
      bus.req_valid = 2'b00;
      bus.rsp_ready = 2'b00;
      bus.req_mode  = 2'b00;
      bus.req_cin   = 2'b00;
      for (int n = 0; n < 2; n++) begin
         bus.req_opa[n] = '0;
         bus.req_opb[n] = '0;
         bus.req_cmd[n] = '0;
         pend[n] = 0;
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_alu_ce", 32'(bus.alu_ce), 1);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_rsp", {bus.rsp_valid, bus.rsp_flags, bus.rsp_res}, 0);
      chk("reset_alu", {bus.alu_ce, bus.alu_inp_valid, bus.alu_opa, bus.alu_opb, bus.alu_cmd, bus.alu_mode, bus.alu_cin}, 0);
      chk("reset_req_ready", 32'(bus.req_ready), 0);
      // contention from reset
      drive_req(0, 8'h01, 8'h02, 4'h0, 1'b1, 1'b0);
      drive_req(1, 8'h03, 8'h04, 4'h0, 1'b1, 1'b0);
      for (int k = 0; k < 4; k++) begin
         serve(0, g, l, r, f);
         chk("contention_grant", g, ce[k]);
         chk("contention_res", 32'(r), (g == 0) ? 9'h003 : 9'h007);
         if (k < 3) drive_req(g, (g == 0) ? 8'h01 : 8'h03, (g == 0) ? 8'h02 : 8'h04, 4'h0, 1'b1, 1'b0);
         ptr = 1 - g;
      end
      serve(0, g, l, r, f);
      ptr = 1 - g;
      // vector table, one requester at a time
      for (int k = 0; k < 8; k++) begin
         drive_req(vt[k].rq, vt[k].a, vt[k].b, vt[k].c, vt[k].m, vt[k].ci);
         serve(0, g, l, r, f);
         chk("vec_grant", g, vt[k].rq);
         chk("vec_lat", l, vt[k].lat);
         chk("vec_res", 32'(r), 32'(vt[k].res));
         chk("vec_flags", 32'(f), 32'(vt[k].flg));
         ptr = 1 - g;
      end
      // backpressure with the other requester waiting
      drive_req(0, 8'h40, 8'h02, 4'h0, 1'b1, 1'b1);
      drive_req(1, 8'h10, 8'h20, 4'h0, 1'b1, 1'b0);
      eg = FIXED ? 0 : ptr;
      serve(10, g, l, r, f);
      chk("bp_grant", g, eg);
      chk("bp_res", 32'(r), (eg == 0) ? 9'h043 : 9'h030);
      serve(0, g, l, r, f);
      chk("bp_second_grant", g, 1 - eg);
      ptr = 1 - g;
      drive_req(0, 8'h01, 8'h01, 4'h0, 1'b1, 1'b0);
      serve(0, g, l, r, f);
      ptr = 1 - g;
      // reset in the middle of WAIT
      drive_req(1, 8'h02, 8'h03, 4'h9, 1'b1, 1'b0);
      #1;
      chk("mw_grant", 32'(bus.req_ready), 2'b10);
      @(negedge clk);
      bus.req_valid[1] = 1'b0;
      @(negedge clk);
      chk("mw_busy", 32'(busy), 1);
      rst = 1'b1;
      #1;
      chk("mw_rst_ce", 32'(bus.alu_ce), 1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mw_busy_after", 32'(busy), 0);
      chk("mw_rsp_after", {bus.rsp_valid, bus.rsp_flags, bus.rsp_res}, 0);
      chk("mw_alu_after", {bus.alu_ce, bus.alu_inp_valid, bus.alu_opa, bus.alu_opb, bus.alu_cmd, bus.alu_mode, bus.alu_cin}, 0);
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.rsp_valid != 2'b00 || busy) seen = 1;
      end
      chk("mw_no_response", seen, 0);
      ptr = 0;
      drive_req(0, 8'h07, 8'h01, 4'h0, 1'b1, 1'b0);
      drive_req(1, 8'h09, 8'h01, 4'h0, 1'b1, 1'b0);
      serve(0, g, l, r, f);
      chk("mw_ptr_reset_grant", g, 0);
      chk("mw_ptr_reset_res", 32'(r), 9'h008);
      ptr = 1 - g;
      serve(0, g, l, r, f);
      chk("mw_second_grant", g, 1);
      ptr = 1 - g;
      // random traffic against the transaction model
      pend[0] = 0;
      pend[1] = 0;
      for (int t = 0; t < 40; t++) begin
         for (int n = 0; n < 2; n++) if (pend[n] == 0 && $urandom_range(1) == 1) rand_op(n);
         if (pend[0] == 0 && pend[1] == 0) rand_op(int'($urandom_range(1)));
         eg = FIXED ? ((pend[0] != 0) ? 0 : 1) : ((pend[0] != 0 && pend[1] != 0) ? ptr : ((pend[1] != 0) ? 1 : 0));
         ex = alu_fn(ra[eg], rb[eg], rc[eg], rm[eg], rci[eg]);
         serve(int'($urandom_range(3)), g, l, r, f);
         chk("rand_grant", g, eg);
         chk("rand_result", {r, f}, ex);
         chk("rand_lat", l, lat_of(rc[eg], rm[eg]) + 2);
         pend[g] = 0;
         ptr = 1 - g;
      end
      bus.req_valid = 2'b00;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DW, default 8, operand width.
REQ-002 Parameter CW, default 4, command width.
REQ-003 Parameter LAT, default 1, ALU result latency in cycles after the issue cycle, for all commands except multiply-class.
REQ-004 Parameter MUL_LAT, default 3, result latency for multiply-class commands (MODE=1, CMD=4'h9 or 4'hA).
REQ-005 CLK  in  1  single clock, all logic on the rising edge.
REQ-006 RST  in  1  reset; synchronous and active-high.
REQ-007 REQn_VALID  in  1  requester n (n=0,1) has an operation pending.
REQ-008 REQn_READY  out  1  requester n operation accepted this cycle.
REQ-009 REQn_OPA, REQn_OPB  in  DW  operands; REQn_CMD  in  CW; REQn_MODE, REQn_CIN  in  1.
REQ-010 RSPn_VALID  out  1  result for requester n is held on RSP_RES/RSP_FLAGS.
REQ-011 RSPn_READY  in  1  requester n consumes the result.
REQ-012 RSP_RES  out  DW+1  captured result; RSP_FLAGS  out  6  {COUT,OFLOW,G,E,L,ERR} captured.
REQ-013 ALU_CE  out  1; ALU_INP_VALID  out  2; ALU_OPA, ALU_OPB  out  DW; ALU_CMD  out  CW; ALU_MODE, ALU_CIN  out  1  ALU drive.
REQ-014 ALU_RES  in  DW+1; ALU_COUT, ALU_OFLOW, ALU_G, ALU_E, ALU_L, ALU_ERR  in  1  ALU outputs.
REQ-015 BUSY  out  1  high in any state other than IDLE.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, RESP; exactly one operation in flight.
REQ-017 IDLE: if any REQn_VALID, grant one requester, pulse its REQn_READY for one cycle, latch its OPA/OPB/CMD/MODE/CIN, and go to ISSUE.
REQ-018 Grant rule: round-robin. The pointer starts at requester 0, and after each completed response it moves to the requester that was not served.
REQ-019 ISSUE (1 cycle): ALU_CE=1, ALU_INP_VALID=2'b11, ALU operand/command ports driven from the latch; load the latency counter with LAT or MUL_LAT; go to WAIT.
REQ-020 WAIT: ALU_CE=1, ALU_INP_VALID=2'b00, ALU operand ports hold the latched values; the counter decrements each cycle.
REQ-021 When the counter reaches 1, capture ALU_RES and the flags at that edge; go to RESP.
REQ-022 Flag capture: a flag bit is 1 only if the ALU input is exactly 1; a z or x input is captured as 0.
REQ-023 RSP_RES bits: each bit that is z or x on ALU_RES is captured as 0.
REQ-024 RESP: assert RSPn_VALID for the granted n only; hold RSP_RES/RSP_FLAGS stable until RSPn_READY=1.
REQ-025 On the RSPn_READY=1 edge: deassert RSPn_VALID, advance the pointer, go to IDLE.
REQ-026 Outside ISSUE/WAIT: ALU_CE=0, ALU_INP_VALID=2'b00.
REQ-027 REQn_VALID is ignored in ISSUE/WAIT/RESP, and REQn_READY stays 0 there.
REQ-028 Requester-held VALID: a request stays pending until its READY pulse, and the block never drops it.
REQ-029 RSPn_READY asserted while RSPn_VALID=0 has no effect.
REQ-030 Back-to-back: the earliest next grant is the cycle after RESP exits (IDLE for 1 cycle minimum).

Reset
REQ-031 RST at a clock edge forces IDLE in any state, including mid-WAIT; an in-flight result is discarded and no response is issued.
REQ-032 Reset values: REQn_READY=0, RSPn_VALID=0, RSP_RES=0, RSP_FLAGS=0, ALU_CE=0, ALU_INP_VALID=0, ALU_OPA/OPB/CMD/MODE/CIN=0, BUSY=0, pointer=0.
REQ-033 Also during RST: ALU_CE=1 for that cycle, so the ALU output reset takes effect.

Configuration
REQ-034 Macro ALU_ARB_FIXED_PRIO_EN, when defined: requester 0 has strict priority over requester 1, and the pointer is unused.
REQ-035 ALU_ARB_FIXED_PRIO_EN not defined: round-robin per REQ-018.

Verification
REQ-036 Single request: REQ0 OPA=8'h05, OPB=8'h03, MODE=1, CMD=0 -> ISSUE one cycle after grant; RSP0_VALID at grant+LAT+2; RSP_RES=9'h008, COUT=0.
REQ-037 Contention: REQ0 and REQ1 both valid from reset for 4 operations -> grants 0,1,0,1 in round-robin; with ALU_ARB_FIXED_PRIO_EN, grants 0,0,0,0 while REQ0 stays valid.
REQ-038 Multiply: MODE=1, CMD=4'h9, OPA=8'h02, OPB=8'h03 -> counter loaded with MUL_LAT; RES captured MUL_LAT cycles after ISSUE and equal to 9'h00C.
REQ-039 Compare: MODE=1, CMD=4'h8, OPA=OPB=8'h11 -> RSP_FLAGS E=1, G=0, L=0 (z captured as 0); RSP_RES=0.
REQ-040 Backpressure: RSP0_READY held 0 for 10 cycles -> RSP_RES stable, REQ1_READY stays 0, BUSY=1 throughout.
REQ-041 Reset mid-WAIT: RST pulsed in WAIT -> next cycle IDLE, all outputs at reset values, no RSPn_VALID for that operation.
